neuro_wb_master: RTL and testbench

NEURO_WB_MASTER -- requirements
Module: neuro_wb_master

---
 rtl/neuro_wb_master.sv | 175 +++++++++++++++++
 tb/tb_neuro_wb_master.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuro_wb_master.sv
// Command-queued classic Wishbone master for the neuromorphic array.
// One bus transaction at a time; each one returns a response with a timeout flag.
module neuro_wb_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 256
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        rsp_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int EW = 69;

  localparam logic [AW:0]   FULL    = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_t;

  state_t state;
  state_t state_d;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [EW-1:0] head;
  logic [CW-1:0] tmo_cnt;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic ack_take;
  logic to_fire;

  assign full  = (count == FULL);
  assign empty = (count == '0);
  assign push  = cmd_valid_i && !full;
  assign head  = mem[rd_ptr];

  assign cmd_ready_o = !full;
  assign rsp_valid_o = (state == RESP);
  assign busy_o      = !empty || (state != IDLE);

  // Queue storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i};
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_d  = state;
    pop      = 1'b0;
    ack_take = 1'b0;
    to_fire  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = BUS;
        end
      end
      BUS: begin
        // An ack on the final counted cycle beats the timeout.
        if (wbm_ack_i) begin
          ack_take = 1'b1;
          state_d  = RESP;
        end else if (tmo_cnt == TO_LAST) begin
          to_fire = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
      tmo_cnt   <= '0;
      rsp_dat_o <= '0;
      rsp_err_o <= 1'b0;
      rsp_we_o  <= 1'b0;
    end else begin
      if (pop) begin
        wbm_we_o  <= head[68];
        wbm_adr_o <= head[67:36];
        wbm_dat_o <= head[35:4];
        wbm_sel_o <= head[3:0];
        wbm_cyc_o <= 1'b1;
        wbm_stb_o <= 1'b1;
        tmo_cnt   <= '0;
      end else if (ack_take) begin
        wbm_cyc_o <= 1'b0;
        wbm_stb_o <= 1'b0;
        rsp_dat_o <= wbm_we_o ? 32'h0 : wbm_dat_i;
        rsp_err_o <= 1'b0;
        rsp_we_o  <= wbm_we_o;
      end else if (to_fire) begin
        wbm_cyc_o <= 1'b0;
        wbm_stb_o <= 1'b0;
        rsp_dat_o <= 32'h0;
        rsp_err_o <= 1'b1;
        rsp_we_o  <= wbm_we_o;
      end else if (state == BUS) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_neuro_wb_master.sv
// Randomized bench for neuro_wb_master with a queue-based transaction model.
// A behavioural slave acks per a per-command plan; responses are scored in order.
module tb_neuro_wb_master;

  localparam int DEPTH = 4;
  localparam int T     = 8;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          ack_j;
    logic [31:0] rdata;
  } cmd_t;

  typedef struct packed {
    logic [31:0] dat;
    logic        err;
    logic        we;
  } rsp_t;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        rsp_we;
  logic        wbm_cyc;
  logic        wbm_stb;
  logic        wbm_we;
  logic [31:0] wbm_adr;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack;
  logic        busy;

  int vectors;
  int miscompares;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  cmd_t cur;
  bit   in_bus;
  int   bus_cycles;
  int   low_cnt;
  bit   seen_tx;
  int   rdy_mode;
  bit   stray_en;

  neuro_wb_master #(
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT(T)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst_n),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr),
    .cmd_dat_i(cmd_dat),
    .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_dat_o(rsp_dat),
    .rsp_err_o(rsp_err),
    .rsp_we_o(rsp_we),
    .wbm_cyc_o(wbm_cyc),
    .wbm_stb_o(wbm_stb),
    .wbm_we_o(wbm_we),
    .wbm_adr_o(wbm_adr),
    .wbm_dat_o(wbm_dat_o),
    .wbm_sel_o(wbm_sel),
    .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack),
    .busy_o(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [71:0] act,
                     input logic [71:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic cmd_t mk(input logic we, input logic [31:0] adr,
                              input logic [31:0] dat, input logic [3:0] sel,
                              input int ack_j, input logic [31:0] rdata);
    cmd_t c;
    c.we = we;
    c.adr = adr;
    c.dat = dat;
    c.sel = sel;
    c.ack_j = ack_j;
    c.rdata = rdata;
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    cmd_t c;
    int r;
    c.we = 1'($urandom_range(0, 1));
    c.adr = $urandom;
    c.dat = $urandom;
    c.sel = 4'($urandom_range(0, 15));
    c.rdata = $urandom;
    r = $urandom_range(0, 9);
    if (r == 0) c.ack_j = 0;
    else if (r == 1) c.ack_j = T;
    else if (r == 2) c.ack_j = T - 1;
    else c.ack_j = $urandom_range(1, 3);
    return c;
  endfunction

  // Model of the transaction stream, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      cmd_q.delete();
      rsp_q.delete();
      in_bus = 0;
      bus_cycles = 0;
      low_cnt = 0;
      seen_tx = 0;
      wbm_ack = 1'b0;
    end else begin
      chk("stb_eq_cyc", wbm_stb, wbm_cyc);
      if (wbm_cyc && !in_bus) begin
        chk("cyc_has_cmd", cmd_q.size() != 0, 1);
        if (cmd_q.size() != 0) begin
          cur = cmd_q.pop_front();
          in_bus = 1;
          bus_cycles = 1;
          if (seen_tx) chk("cyc_gap", low_cnt >= 2, 1);
          chk("bus_fields", {wbm_we, wbm_adr, wbm_dat_o, wbm_sel},
              {cur.we, cur.adr, cur.dat, cur.sel});
        end
      end else if (wbm_cyc && in_bus) begin
        bus_cycles++;
        chk("bus_stable", {wbm_we, wbm_adr, wbm_dat_o, wbm_sel},
            {cur.we, cur.adr, cur.dat, cur.sel});
        chk("bus_len_bound", bus_cycles <= T, 1);
      end else if (!wbm_cyc && in_bus) begin
        int exp_len;
        rsp_t r;
        bit acked;
        acked = (cur.ack_j >= 1) && (cur.ack_j <= T);
        exp_len = acked ? cur.ack_j : T;
        chk("bus_len", bus_cycles, exp_len);
        r.dat = (acked && !cur.we) ? cur.rdata : 32'h0;
        r.err = !acked;
        r.we = cur.we;
        rsp_q.push_back(r);
        in_bus = 0;
        seen_tx = 1;
        low_cnt = 1;
      end else begin
        low_cnt++;
      end
      chk("cmd_ready", cmd_ready, cmd_q.size() < DEPTH);
      chk("busy", busy, cmd_q.size() != 0 || in_bus || rsp_q.size() != 0);
      chk("rsp_valid", rsp_valid, rsp_q.size() != 0);
      case (rdy_mode)
        0: rsp_ready = 1'b1;
        1: rsp_ready = 1'($urandom_range(0, 1));
        default: rsp_ready = 1'b0;
      endcase
      if (rsp_valid && rsp_q.size() != 0) begin
        chk("rsp", {rsp_dat, rsp_err, rsp_we}, rsp_q[0]);
        if (rsp_ready) void'(rsp_q.pop_front());
      end
      if (wbm_cyc && in_bus) begin
        wbm_ack = (cur.ack_j == bus_cycles);
        wbm_dat_i = wbm_ack ? cur.rdata : $urandom;
      end else begin
        wbm_ack = stray_en && ($urandom_range(0, 3) == 0);
        wbm_dat_i = $urandom;
      end
    end
  end

  task automatic push(input cmd_t c);
    bit ok;
    ok = 0;
    @(negedge clk);
    #2;
    cmd_valid = 1'b1;
    cmd_we = c.we;
    cmd_adr = c.adr;
    cmd_dat = c.dat;
    cmd_sel = c.sel;
    for (int k = 0; k < 200; k++) begin
      if (cmd_ready) begin
        cmd_q.push_back(c);
        @(posedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
      #2;
    end
    #1;
    cmd_valid = 1'b0;
    chk("cmd_accept", ok, 1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      #3;
      if (!busy && cmd_q.size() == 0 && !in_bus && rsp_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    chk("drain", done, 1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_bus"}, {wbm_cyc, wbm_stb, wbm_we, wbm_adr, wbm_dat_o, wbm_sel}, '0);
    chk({tag, "_rsp"}, {rsp_valid, rsp_dat, rsp_err, rsp_we}, '0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, cmd_ready, 1);
  endtask

  initial begin
    #100000;
    miscompares++;
    $display("FAIL watchdog: got timeout want completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_we = 1'b0;
    cmd_adr = '0;
    cmd_dat = '0;
    cmd_sel = '0;
    rsp_ready = 1'b1;
    wbm_ack = 1'b0;
    wbm_dat_i = '0;
    rdy_mode = 0;
    stray_en = 0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outs("reset");
    #2;
    rst_n = 1'b1;

    push(mk(1'b1, 32'h3000_0004, 32'hA5A5_0001, 4'hF, 3, 32'hDEAD_BEEF));
    wait_idle();
    push(mk(1'b0, 32'h3000_0008, 32'h1234_5678, 4'h3, 2, 32'h0000_00FF));
    wait_idle();
    push(mk(1'b0, 32'h3000_000C, 32'h0, 4'hF, 0, 32'h5555_AAAA));
    push(mk(1'b0, 32'h3000_0010, 32'h0, 4'h1, 1, 32'h0BAD_F00D));
    wait_idle();
    push(mk(1'b0, 32'h3000_0014, 32'h0, 4'hC, T, 32'hC0FF_EE00));
    push(mk(1'b1, 32'h3000_0018, 32'h77, 4'h2, T - 1, 32'h1));
    wait_idle();

    push(mk(1'b1, 32'h3000_0020, 32'h42, 4'hF, 1, 32'h0));
    @(negedge clk);
    #1;
    chk("lat_n", {wbm_cyc, busy}, 2'b01);
    @(negedge clk);
    #1;
    chk("lat_n1", wbm_cyc, 1);
    wait_idle();

    stray_en = 1;
    repeat (12) @(negedge clk);
    stray_en = 0;
    wait_idle();

    rdy_mode = 2;
    for (int i = 0; i < 5; i++) begin
      push(mk(i[0], 32'h4000_0000 + 32'(i * 4), 32'(i + 100), 4'hF, 1, 32'(i + 200)));
    end
    repeat (3) @(negedge clk);
    #1;
    chk("bp_full", {cmd_ready, rsp_valid}, 2'b01);
    fork
      push(mk(1'b0, 32'h4000_0014, 32'h0, 4'h5, 1, 32'h6666_0006));
      begin
        repeat (6) @(negedge clk);
        rdy_mode = 0;
      end
    join
    wait_idle();

    push(mk(1'b0, 32'h5000_0000, 32'h0, 4'hF, 0, 32'h0));
    push(mk(1'b1, 32'h5000_0004, 32'h9, 4'hF, 0, 32'h0));
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (wbm_cyc) break;
    end
    repeat (2) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("rst_mid");
    repeat (2) @(negedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst", {busy, cmd_ready, rsp_valid, wbm_cyc}, 4'b0100);
    push(mk(1'b0, 32'h5000_0008, 32'h0, 4'hA, 2, 32'hFACE_0001));
    wait_idle();

    rdy_mode = 1;
    stray_en = 1;
    for (int i = 0; i < 40; i++) begin
      push(rand_cmd());
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 6)) @(negedge clk);
      end
    end
    wait_idle();
    stray_en = 0;
    rdy_mode = 0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
